sequence_generator: RTL

Serial pattern transmitter that pairs with the sequence detector on the same single-bit line. It accepts a WIDTH-bit pattern and a repetition count through a start/ready handshake. It then emits the pattern MSB-first, one bit per clock, for the requested number of repetitions, with a configurable idle gap between repetitions. Its `out_bit` drives the detector's `in_bit`, either in stimulus benches or in loopback self-test.

---
 rtl/seq_gen_pkg.sv | 22 ++
 rtl/piso_shift_reg.sv | 34 +++
 rtl/sequence_generator.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/seq_gen_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // Counter width for a count range of n values, never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load, serial-out shifter, MSB first; load has priority over shift.
module piso_shift_reg
  import seq_gen_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb,
  output logic             next_msb
);

  logic [WIDTH-1:0] data_r;

  // Shift register storage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_r <= '0;
    end else if (load) begin
      data_r <= din;
    end else if (shift) begin
      data_r <= {data_r[WIDTH-2:0], 1'b0};
    end else begin
      data_r <= data_r;
    end
  end

  assign msb      = data_r[WIDTH-1];
  assign next_msb = data_r[WIDTH-2];

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: sends a captured pattern MSB-first for a number
// of repetitions with an optional idle gap between repetitions.
module sequence_generator
  import seq_gen_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int REP_W = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [REP_W-1:0] reps,
  output logic             ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             frame_end,
  output logic             done
);

  localparam int BIT_W = cnt_width(WIDTH);
  localparam int GAP_W = cnt_width(GAP + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP > 0) ? (GAP - 1) : 0);

  state_t           state_r, state_n;
  logic [BIT_W-1:0] bit_cnt_r, bit_n;
  logic [GAP_W-1:0] gap_cnt_r, gap_n;
  logic [REP_W-1:0] rep_cnt_r, rep_n;
  logic [WIDTH-1:0] pat_r, pat_n;

  logic             load_s, shift_s;
  logic [WIDTH-1:0] load_val_s;
  logic             sh_msb_s, sh_next_s;

  logic             ready_n, valid_n, bit_out_n, fe_n, done_n;

  piso_shift_reg #(.WIDTH(WIDTH)) u_piso (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .shift    (shift_s),
    .din      (load_val_s),
    .msb      (sh_msb_s),
    .next_msb (sh_next_s)
  );

  // Next-state, counter and next-output logic; outputs describe the coming cycle.
  always_comb begin
    state_n    = state_r;
    bit_n      = bit_cnt_r;
    gap_n      = gap_cnt_r;
    rep_n      = rep_cnt_r;
    pat_n      = pat_r;
    load_s     = 1'b0;
    shift_s    = 1'b0;
    load_val_s = pat_r;
    ready_n    = 1'b0;
    valid_n    = 1'b0;
    bit_out_n  = 1'b0;
    fe_n       = 1'b0;
    done_n     = 1'b0;

    case (state_r)
      S_IDLE: begin
        ready_n = 1'b1;
        if (start) begin
          pat_n = pattern;
          rep_n = reps;
          bit_n = '0;
          gap_n = '0;
          if (reps == '0) begin
            done_n = 1'b1;
          end else begin
            state_n    = S_SEND;
            load_s     = 1'b1;
            load_val_s = pattern;
            ready_n    = 1'b0;
            valid_n    = 1'b1;
            bit_out_n  = pattern[WIDTH-1];
          end
        end else begin
          state_n = S_IDLE;
        end
      end

      S_SEND: begin
        if (bit_cnt_r != LAST_BIT) begin
          shift_s   = 1'b1;
          bit_n     = bit_cnt_r + BIT_W'(1);
          valid_n   = 1'b1;
          bit_out_n = sh_next_s;
          fe_n      = (bit_n == LAST_BIT);
        end else begin
          // Last bit of a repetition is on the line now: reload for the next one.
          rep_n  = rep_cnt_r - REP_W'(1);
          load_s = 1'b1;
          bit_n  = '0;
          gap_n  = '0;
          if (rep_cnt_r == REP_W'(1)) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
            ready_n = 1'b1;
          end else if (GAP > 0) begin
            state_n = S_GAP;
          end else begin
            state_n   = S_SEND;
            valid_n   = 1'b1;
            bit_out_n = pat_r[WIDTH-1];
          end
        end
      end

      S_GAP: begin
        if (gap_cnt_r == LAST_GAP) begin
          state_n   = S_SEND;
          gap_n     = '0;
          valid_n   = 1'b1;
          bit_out_n = sh_msb_s;
        end else begin
          gap_n = gap_cnt_r + GAP_W'(1);
        end
      end

      default: begin
        state_n = S_IDLE;
        ready_n = 1'b1;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= S_IDLE;
      bit_cnt_r <= '0;
      gap_cnt_r <= '0;
      rep_cnt_r <= '0;
      pat_r     <= '0;
      ready     <= 1'b1;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      frame_end <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_n;
      bit_cnt_r <= bit_n;
      gap_cnt_r <= gap_n;
      rep_cnt_r <= rep_n;
      pat_r     <= pat_n;
      ready     <= ready_n;
      out_valid <= valid_n;
      out_bit   <= bit_out_n;
      frame_end <= fe_n;
      done      <= done_n;
    end
  end

endmodule
